// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: hits drive idata combinationally (0 cycles).
// Misses raise istall and refill the whole line in order over a req/ack read port that may insert wait states.
module icache #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] iaddr,
  output logic [31:0] idata,
  output logic        istall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int OB = 2 + OW;
  localparam int TW = 32 - OB - IW;

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*WORDS];

  logic [OW-1:0]    cnt;
  logic [31-OB:0]   line;
  logic             flush_pend;

  logic [OW-1:0]    off;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    tag;
  logic [IW-1:0]    fill_idx;
  logic [TW-1:0]    fill_tag;
  logic             hit;
  logic             last;
  logic             unused_bits;

  assign off      = iaddr[OB-1:2];
  assign idx      = iaddr[OB+IW-1:OB];
  assign tag      = iaddr[31:OB+IW];
  assign fill_idx = line[IW-1:0];
  assign fill_tag = line[31-OB:IW];
  assign last     = (cnt == OW'(WORDS - 1));
  assign unused_bits = ^iaddr[1:0];

  assign hit      = valid[idx] && (tag_mem[idx] == tag) && (state == IDLE) && !rst;
  assign istall   = !hit;
  assign idata    = data_mem[{idx, off}];
  assign mem_addr = {line, cnt, 2'b00};

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (!hit) state_nxt = FILL;
      end
      FILL: begin
        mem_req = 1'b1;
        if (mem_ack && last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid      <= '0;
      flush_pend <= 1'b0;
      cnt        <= '0;
      line       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (flush) valid <= '0;
          if (!hit) begin
            line <= iaddr[31:OB];
            cnt  <= '0;
          end
        end
        FILL: begin
          if (flush) begin
            valid      <= '0;
            flush_pend <= 1'b1;
          end
          if (mem_ack) begin
            cnt <= cnt + 1'b1;
            if (last) begin
              // a flush seen at any point during the fill leaves this line invalid
              valid[fill_idx] <= !(flush_pend || flush);
              flush_pend      <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (!rst && state == FILL && mem_ack) begin
      data_mem[{fill_idx, cnt}] <= mem_rdata;
      if (last) tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule
